// File: rtl/cix32_pkg.sv
// rtl/cix32_pkg.sv - shared types for the cix32 writeback queue
package cix32_pkg;

  typedef enum logic [1:0] {
    OP_BYTE  = 2'b00,
    OP_WORD  = 2'b01,
    OP_DWORD = 2'b10,
    OP_RSVD  = 2'b11
  } opsize_e;

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  typedef struct packed {
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wb_entry_t;

endpackage

// File: rtl/cix32_wb_align.sv
// rtl/cix32_wb_align.sv - maps x86 reg/size/data to a physical GPR write entry
module cix32_wb_align
  import cix32_pkg::*;
(
  input  logic [2:0]  reg_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] data_i,
  output wb_entry_t   entry_o,
  output logic        illegal_o
);

  always_comb begin
    entry_o   = '0;
    illegal_o = 1'b0;
    case (opsize_e'(size_i))
      OP_BYTE: begin
        // Byte encodings 4-7 name AH..BH, the high byte of EAX..EBX
        if (reg_i[2]) begin
          entry_o.waddr = {1'b0, reg_i[1:0]};
          entry_o.wstrb = 4'b0010;
          entry_o.wdata = {16'h0000, data_i[7:0], 8'h00};
        end else begin
          entry_o.waddr = reg_i;
          entry_o.wstrb = 4'b0001;
          entry_o.wdata = {24'h000000, data_i[7:0]};
        end
      end
      OP_WORD: begin
        entry_o.waddr = reg_i;
        entry_o.wstrb = 4'b0011;
        entry_o.wdata = {16'h0000, data_i[15:0]};
      end
      OP_DWORD: begin
        entry_o.waddr = reg_i;
        entry_o.wstrb = 4'b1111;
        entry_o.wdata = data_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cix32_wb_queue.sv
// rtl/cix32_wb_queue.sv - in-order writeback FIFO with per-GPR pending scoreboard
// Optional same-cycle bypass into the register file: CIX32_WB_BYPASS_EN
module cix32_wb_queue
  import cix32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_reg,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_data,
  input  logic        rf_hold,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  rf_wstrb,
  output logic [7:0]  busy,
  output logic        empty,
  output logic        full,
  output logic        size_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t             mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q [8];
  logic [CNT_W-1:0]      cnt_d [8];
  logic                  size_err_q, size_err_d;

  wb_entry_t in_entry, head;
  logic      in_illegal, accept, enq, pop, byp;

  cix32_wb_align u_align (
    .reg_i     (in_reg),
    .size_i    (in_size),
    .data_i    (in_data),
    .entry_o   (in_entry),
    .illegal_o (in_illegal)
  );

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  // Gated by rst_n so a reset cycle never commits a register write
  assign pop      = rst_n && !empty && !rf_hold;

`ifdef CIX32_WB_BYPASS_EN
  assign byp = rst_n && empty && !rf_hold && in_valid && !in_illegal;
`else
  assign byp = 1'b0;
`endif

  assign enq        = accept && !in_illegal && !byp;
  assign size_err_d = accept && in_illegal;
  assign rf_we      = pop || byp;
  assign rf_waddr   = byp ? in_entry.waddr : head.waddr;
  assign rf_wdata   = byp ? in_entry.wdata : head.wdata;
  assign rf_wstrb   = byp ? in_entry.wstrb : head.wstrb;
  assign size_err   = size_err_q;

  assign wr_ptr_d = enq ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({enq && (in_entry.waddr == 3'(i)), pop && (head.waddr == 3'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      busy[i] = (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      size_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      size_err_q <= size_err_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
  end

endmodule
